// File: rtl/CPU_package.sv
// CPU_package: shared datapath widths and the memory access controller FSM encoding.
package CPU_package;
    localparam int DATA_WIDTH    = 8;
    localparam int ADDRESS_WIDTH = 4;
    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ_WAIT,
        CAPTURE,
        RESP,
        VREAD,
        VCHECK
    } mem_ctrl_state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at all-ones, async active-low clear.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;
endmodule

// File: rtl/mem_access_controller.sv
// mem_access_controller: serial load/store sequencer for Data_Memory with registered read.
// Define MEM_STORE_VERIFY_EN to read back every store and flag mismatches on verify_err.
module mem_access_controller
    import CPU_package::*;
#(
    parameter int DATA_WIDTH    = CPU_package::DATA_WIDTH,
    parameter int ADDRESS_WIDTH = CPU_package::ADDRESS_WIDTH,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_write,
    input  logic [ADDRESS_WIDTH-1:0] req_address,
    input  logic [DATA_WIDTH-1:0]    req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic [ADDRESS_WIDTH-1:0] write_address,
    output logic                     Write_Enable,
    output logic [DATA_WIDTH-1:0]    DATA_WRITE,
    output logic [ADDRESS_WIDTH-1:0] read_address,
    output logic                     Read_Enable,
    input  logic [DATA_WIDTH-1:0]    DATA_READ,
    output logic [CNT_WIDTH-1:0]     load_count,
    output logic [CNT_WIDTH-1:0]     store_count,
    output logic                     verify_err
);
`ifdef MEM_STORE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    mem_ctrl_state_t           state, state_nxt;
    logic                      accept, inc_load, inc_store;
    logic                      req_ready_nxt, we_nxt, re_nxt, rsp_valid_nxt;
    logic [ADDRESS_WIDTH-1:0]  wa_nxt, ra_nxt;
    logic [DATA_WIDTH-1:0]     dw_nxt, rd_nxt;

    // req_ready is high only in IDLE, so a handshake implies IDLE
    assign accept = req_valid && req_ready;

    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            Write_Enable  <= 1'b0;
            Read_Enable   <= 1'b0;
            rsp_valid     <= 1'b0;
            write_address <= '0;
            read_address  <= '0;
            DATA_WRITE    <= '0;
            rsp_rdata     <= '0;
        end else begin
            state         <= state_nxt;
            req_ready     <= req_ready_nxt;
            Write_Enable  <= we_nxt;
            Read_Enable   <= re_nxt;
            rsp_valid     <= rsp_valid_nxt;
            write_address <= wa_nxt;
            read_address  <= ra_nxt;
            DATA_WRITE    <= dw_nxt;
            rsp_rdata     <= rd_nxt;
        end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = accept ? (req_write ? WRITE : READ_WAIT) : IDLE;
            WRITE:     state_nxt = VERIFY ? VREAD : IDLE;
            READ_WAIT: state_nxt = CAPTURE;
            CAPTURE:   state_nxt = RESP;
            RESP:      state_nxt = rsp_ready ? IDLE : RESP;
            VREAD:     state_nxt = VCHECK;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready_nxt = state_nxt == IDLE;
        we_nxt        = state_nxt == WRITE;
        re_nxt        = state_nxt == READ_WAIT || state_nxt == VREAD;
        rsp_valid_nxt = state_nxt == RESP;
        wa_nxt        = accept ? req_address : write_address;
        dw_nxt        = accept ? req_wdata : DATA_WRITE;
        // verify read-back reuses the read port at the address just stored
        ra_nxt        = accept ? req_address : (VERIFY && state == WRITE) ? write_address : read_address;
        rd_nxt        = state == CAPTURE ? DATA_READ : rsp_rdata;
        inc_load      = state == RESP && rsp_ready;
        inc_store     = VERIFY ? state == VCHECK : state == WRITE;
    end

`ifdef MEM_STORE_VERIFY_EN
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n)
            verify_err <= 1'b0;
        else if (state == VCHECK && DATA_READ != DATA_WRITE)
            verify_err <= 1'b1;
`else
    assign verify_err = 1'b0;
`endif

    sat_counter #(.WIDTH(CNT_WIDTH)) u_load_cnt (
        .clock  (clock),
        .reset_n(reset_n),
        .inc    (inc_load),
        .count  (load_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_store_cnt (
        .clock  (clock),
        .reset_n(reset_n),
        .inc    (inc_store),
        .count  (store_count)
    );
endmodule

// File: tb/tb_mem_access_controller.sv
// tb_mem_access_controller: directed checks of mem_access_controller against a Data_Memory model.
module tb_mem_access_controller;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       req_valid, req_ready, req_write;
    logic [3:0] req_address;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_rdata;
    logic [3:0] write_address, read_address;
    logic       Write_Enable, Read_Enable;
    logic [7:0] DATA_WRITE;
    logic [7:0] DATA_READ;
    logic [7:0] load_count, store_count;
    logic       verify_err;
    logic [7:0] mem [16];
    logic       corrupt;
    logic [7:0] exp_load, exp_store;
    int         vectors = 0;
    int         errors  = 0;

    always #5 clock = ~clock;

    mem_access_controller #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .CNT_WIDTH(8)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_address  (req_address),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .write_address(write_address),
        .Write_Enable (Write_Enable),
        .DATA_WRITE   (DATA_WRITE),
        .read_address (read_address),
        .Read_Enable  (Read_Enable),
        .DATA_READ    (DATA_READ),
        .load_count   (load_count),
        .store_count  (store_count),
        .verify_err   (verify_err)
    );

    // Data_Memory: write on clock edge, registered read; address 3 can be forced to store inverted data
    always @(posedge clock) begin
        if (Write_Enable)
            mem[write_address] <= (corrupt && write_address == 4'h3) ? ~DATA_WRITE : DATA_WRITE;
        if (Read_Enable)
            DATA_READ <= mem[read_address];
    end

    always @(negedge clock)
        if (reset_n && Write_Enable && Read_Enable) begin
            vectors++;
            errors++;
            $display("FAIL enables_exclusive: Write_Enable=%b Read_Enable=%b, required not both 1", Write_Enable, Read_Enable);
        end

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
    endtask

    // returns at the falling edge right after the accepting rising edge
    task automatic issue(input logic w, input logic [3:0] a, input logic [7:0] d, output bit ok);
        req_write = w;
        req_address = a;
        req_wdata = d;
        req_valid = 1'b1;
        wait_ready(ok);
        if (ok)
            @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic do_store(input logic [3:0] a, input logic [7:0] d, output bit ok);
        bit iok;
        issue(1'b1, a, d, iok);
        wait_ready(ok);
        ok = ok && iok;
    endtask

    task automatic do_load(input logic [3:0] a, output logic [7:0] d, output bit ok);
        bit iok;
        d = '0;
        ok = 1'b0;
        rsp_ready = 1'b1;
        issue(1'b0, a, 8'h00, iok);
        if (iok)
            for (int i = 0; i < 20; i++) begin
                @(negedge clock);
                if (rsp_valid) begin
                    d = rsp_rdata;
                    ok = 1'b1;
                    break;
                end
            end
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        vectors++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        vectors++;
        if ({rsp_valid, Write_Enable, Read_Enable, verify_err} !== 4'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 0000", {rsp_valid, Write_Enable, Read_Enable, verify_err});
        end
        vectors++;
        if ({load_count, store_count} !== 16'h0) begin
            errors++; $display("FAIL reset_counts: got %h/%h want 00/00", load_count, store_count);
        end
        vectors++;
        if ({rsp_rdata, DATA_WRITE, write_address, read_address} !== 24'h0) begin
            errors++; $display("FAIL reset_data: got %h want 0", {rsp_rdata, DATA_WRITE, write_address, read_address});
        end
    endtask

    task automatic test_store_load;
        bit ok;
        issue(1'b1, 4'h9, 8'hC5, ok);
        vectors++;
        if (!ok || Write_Enable !== 1'b1 || write_address !== 4'h9 || DATA_WRITE !== 8'hC5 || req_ready !== 1'b0) begin
            errors++; $display("FAIL store_issue: got ok=%b we=%b wa=%h dw=%h rdy=%b want 1 1 9 c5 0", ok, Write_Enable, write_address, DATA_WRITE, req_ready);
        end
        @(negedge clock);
        vectors++;
        if (Write_Enable !== 1'b0) begin errors++; $display("FAIL store_we_pulse: got %b want 0", Write_Enable); end
`ifdef MEM_STORE_VERIFY_EN
        vectors++;
        if (Read_Enable !== 1'b1 || read_address !== 4'h9 || req_ready !== 1'b0) begin
            errors++; $display("FAIL verify_read: got re=%b ra=%h rdy=%b want 1 9 0", Read_Enable, read_address, req_ready);
        end
        @(negedge clock);
        vectors++;
        if (req_ready !== 1'b0) begin errors++; $display("FAIL verify_occupancy: got rdy=%b want 0", req_ready); end
        @(negedge clock);
`endif
        exp_store++;
        vectors++;
        if (req_ready !== 1'b1 || store_count !== exp_store) begin
            errors++; $display("FAIL store_done: got rdy=%b cnt=%h want 1 %h", req_ready, store_count, exp_store);
        end
        rsp_ready = 1'b0;
        issue(1'b0, 4'h9, 8'h00, ok);
        vectors++;
        if (!ok || Read_Enable !== 1'b1 || read_address !== 4'h9 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL load_issue: got ok=%b re=%b ra=%h v=%b want 1 1 9 0", ok, Read_Enable, read_address, rsp_valid);
        end
        @(negedge clock);
        vectors++;
        if (Read_Enable !== 1'b0 || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL load_wait: got re=%b v=%b want 0 0", Read_Enable, rsp_valid);
        end
        @(negedge clock);
        vectors++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hC5) begin
            errors++; $display("FAIL load_latency: got v=%b d=%h want 1 c5", rsp_valid, rsp_rdata);
        end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        exp_load++;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || load_count !== exp_load) begin
            errors++; $display("FAIL load_done: got v=%b rdy=%b cnt=%h want 0 1 %h", rsp_valid, req_ready, load_count, exp_load);
        end
    endtask

    task automatic test_order;
        bit ok0, ok1, ok2;
        logic [7:0] d0, d1, d2;
        do_store(4'hF, 8'h09, ok0);
        do_store(4'h1, 8'h0F, ok1);
        do_store(4'h0, 8'h5A, ok2);
        vectors++;
        if (!(ok0 && ok1 && ok2)) begin errors++; $display("FAIL order_stores: got ok=%b%b%b want 111", ok0, ok1, ok2); end
        do_load(4'hF, d0, ok0);
        do_load(4'h1, d1, ok1);
        do_load(4'h0, d2, ok2);
        vectors++;
        if (!ok0 || d0 !== 8'h09) begin errors++; $display("FAIL order_load_f: got ok=%b d=%h want 1 09", ok0, d0); end
        vectors++;
        if (!ok1 || d1 !== 8'h0F) begin errors++; $display("FAIL order_load_1: got ok=%b d=%h want 1 0f", ok1, d1); end
        vectors++;
        if (!ok2 || d2 !== 8'h5A) begin errors++; $display("FAIL order_load_0: got ok=%b d=%h want 1 5a", ok2, d2); end
        exp_store += 3;
        exp_load += 3;
        vectors++;
        if (store_count !== exp_store || load_count !== exp_load) begin
            errors++; $display("FAIL order_counts: got %h/%h want %h/%h", store_count, load_count, exp_store, exp_load);
        end
    endtask

    task automatic test_backpressure;
        bit ok;
        logic [7:0] d;
        rsp_ready = 1'b0;
        issue(1'b0, 4'h9, 8'h00, ok);
        repeat (2) @(negedge clock);
        vectors++;
        if (!ok || rsp_valid !== 1'b1 || rsp_rdata !== 8'hC5) begin
            errors++; $display("FAIL bp_first: got ok=%b v=%b d=%h want 1 1 c5", ok, rsp_valid, rsp_rdata);
        end
        req_write = 1'b1;
        req_address = 4'h9;
        req_wdata = 8'h11;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== 8'hC5 || req_ready !== 1'b0 || Write_Enable !== 1'b0) begin
                errors++; $display("FAIL bp_hold%0d: got v=%b d=%h rdy=%b we=%b want 1 c5 0 0", i, rsp_valid, rsp_rdata, req_ready, Write_Enable);
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        exp_load++;
        vectors++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || load_count !== exp_load || store_count !== exp_store) begin
            errors++; $display("FAIL bp_release: got v=%b rdy=%b l=%h s=%h want 0 1 %h %h", rsp_valid, req_ready, load_count, store_count, exp_load, exp_store);
        end
        do_load(4'h9, d, ok);
        exp_load++;
        vectors++;
        if (!ok || d !== 8'hC5) begin errors++; $display("FAIL bp_ignored_store: got ok=%b d=%h want 1 c5", ok, d); end
    endtask

    task automatic test_reset_mid;
        bit ok;
        rsp_ready = 1'b0;
        issue(1'b0, 4'h1, 8'h00, ok);
        vectors++;
        if (!ok || Read_Enable !== 1'b1) begin errors++; $display("FAIL mid_read_wait: got ok=%b re=%b want 1 1", ok, Read_Enable); end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if (Read_Enable !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1 || {load_count, store_count} !== 16'h0) begin
            errors++; $display("FAIL mid_async: got re=%b v=%b rdy=%b cnt=%h want 0 0 1 0000", Read_Enable, rsp_valid, req_ready, {load_count, store_count});
        end
        @(negedge clock);
        reset_n = 1'b1;
        exp_load = '0;
        exp_store = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            vectors++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || {load_count, store_count} !== 16'h0) begin
                errors++; $display("FAIL mid_after%0d: got v=%b rdy=%b cnt=%h want 0 1 0000", i, rsp_valid, req_ready, {load_count, store_count});
            end
        end
    endtask

    task automatic test_verify;
        bit ok;
        logic [7:0] d;
        corrupt = 1'b1;
        do_store(4'h3, 8'hAA, ok);
        corrupt = 1'b0;
        exp_store++;
`ifdef MEM_STORE_VERIFY_EN
        vectors++;
        if (!ok || verify_err !== 1'b1) begin errors++; $display("FAIL verify_set: got ok=%b err=%b want 1 1", ok, verify_err); end
`else
        vectors++;
        if (!ok || verify_err !== 1'b0) begin errors++; $display("FAIL verify_tied: got ok=%b err=%b want 1 0", ok, verify_err); end
`endif
        do_store(4'h4, 8'h55, ok);
        exp_store++;
        do_load(4'h4, d, ok);
        exp_load++;
        vectors++;
        if (!ok || d !== 8'h55) begin errors++; $display("FAIL verify_good_load: got ok=%b d=%h want 1 55", ok, d); end
`ifdef MEM_STORE_VERIFY_EN
        vectors++;
        if (verify_err !== 1'b1) begin errors++; $display("FAIL verify_sticky: got %b want 1", verify_err); end
`else
        vectors++;
        if (verify_err !== 1'b0) begin errors++; $display("FAIL verify_tied2: got %b want 0", verify_err); end
`endif
        vectors++;
        if (store_count !== exp_store || load_count !== exp_load) begin
            errors++; $display("FAIL verify_counts: got %h/%h want %h/%h", store_count, load_count, exp_store, exp_load);
        end
    endtask

    task automatic test_saturation;
        bit ok;
        int n = 0;
        req_write = 1'b1;
        req_valid = 1'b1;
        for (int c = 0; c < 3000 && n < 260; c++) begin
            req_address = n[3:0];
            req_wdata = n[7:0];
            if (req_ready)
                n++;
            @(negedge clock);
        end
        req_valid = 1'b0;
        wait_ready(ok);
        vectors++;
        if (n != 260 || !ok) begin errors++; $display("FAIL sat_progress: got %0d stores ok=%b want 260 1", n, ok); end
        vectors++;
        if (store_count !== 8'hFF) begin errors++; $display("FAIL sat_store: got %h want ff", store_count); end
        vectors++;
        if (load_count !== exp_load) begin errors++; $display("FAIL sat_load: got %h want %h", load_count, exp_load); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++)
            mem[i] = 8'h00;
        DATA_READ = 8'h00;
        corrupt = 1'b0;
        reset_n = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_address = 4'h0;
        req_wdata = 8'h00;
        rsp_ready = 1'b0;
        exp_load = '0;
        exp_store = '0;
        repeat (2) @(negedge clock);
        test_reset;
        reset_n = 1'b1;
        @(negedge clock);
        test_store_load;
        test_order;
        test_backpressure;
        test_reset_mid;
        test_verify;
        test_saturation;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mem_access_controller.md
Name: mem_access_controller

Overview:
- Single-clock initiator that drives the Data_Memory write and read ports for the CPU datapath.
- Accepts one load or store at a time over a valid/ready request channel.
- Sequences Write_Enable and Read_Enable around the memory's registered read.
- Returns load data over a valid/ready response channel and keeps saturating access counters.
- Both Data_Memory clocks (Write_clock, Read_clock) are tied to this block's clock at top level.

Parameters:
DATA_WIDTH, CPU_package::DATA_WIDTH (8), data word width
ADDRESS_WIDTH, CPU_package::ADDRESS_WIDTH (4), memory address width
CNT_WIDTH, 16, width of the load and store counters

Ports:
clock  input  1  single clock for this block and both Data_Memory clocks
reset_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  controller can accept a request
req_write  input  1  1 = store, 0 = load
req_address  input  ADDRESS_WIDTH  target address
req_wdata  input  DATA_WIDTH  store data
rsp_valid  output  1  load data valid
rsp_ready  input  1  consumer accepts the response
rsp_rdata  output  DATA_WIDTH  load data
write_address  output  ADDRESS_WIDTH  to Data_Memory
Write_Enable  output  1  to Data_Memory
DATA_WRITE  output  DATA_WIDTH  to Data_Memory
read_address  output  ADDRESS_WIDTH  to Data_Memory
Read_Enable  output  1  to Data_Memory
DATA_READ  input  DATA_WIDTH  from Data_Memory; valid after the edge that sampled Read_Enable=1
load_count  output  CNT_WIDTH  completed loads, saturating
store_count  output  CNT_WIDTH  completed stores, saturating
verify_err  output  1  sticky store-verify mismatch flag

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State goes to IDLE.
  - All outputs go to 0, except req_ready=1.
  - Any in-flight access is dropped with no response.
  - Counters clear.
- All outputs are registered.
- IDLE:
  - req_ready=1.
  - A transfer occurs when req_valid && req_ready at a rising edge (edge E0).
  - Store: latch write_address and DATA_WRITE, set Write_Enable=1, go to WRITE.
  - Load: latch read_address, set Read_Enable=1, go to READ_WAIT.
  - req_ready drops in the same update.
- WRITE:
  - One cycle; the memory writes at E1.
  - At E1: Write_Enable=0, store_count+1, return to IDLE (req_ready=1).
  - Store throughput is 1 per 2 cycles.
- READ_WAIT:
  - The memory samples at E1; at E1 Read_Enable=0, go to CAPTURE.
- CAPTURE:
  - At E2: rsp_rdata<=DATA_READ, rsp_valid=1, go to RESP.
  - Load latency from the accept edge to rsp_valid is exactly 2 cycles.
- RESP:
  - rsp_valid and rsp_rdata hold stable until rsp_ready=1 at an edge.
  - On that edge: rsp_valid=0, load_count+1, return to IDLE.
  - If rsp_ready is already high when rsp_valid rises, completion happens at the next edge.
- Never more than one access outstanding.
- Write_Enable and Read_Enable are never high in the same cycle.
- req_* inputs are ignored while req_ready=0.
- Counters saturate at all-ones and do not wrap.
- Addresses use the full ADDRESS_WIDTH range. 0 and 2^ADDRESS_WIDTH-1 are legal; there is no range check.
- A load immediately after a store to the same address returns the new data; ordering is guaranteed by the serial FSM.
- Reset asserted mid-access drops the access immediately; memory contents may or may not contain a partially sequenced store.

Optional Feature:
- Macro: MEM_STORE_VERIFY_EN.
- Defined:
  - After WRITE, the FSM goes through VREAD (Read_Enable=1 at the stored address) and then VCHECK (compare DATA_READ with the latched data) before IDLE.
  - On mismatch, verify_err sets and stays set until reset.
  - Store occupancy becomes 4 cycles.
  - store_count increments at VCHECK exit.
- Not defined: verify_err is tied to 0 and the VREAD/VCHECK states are absent.
- The port list is identical in both builds.

Decomposition:
- CPU_package holds DATA_WIDTH and ADDRESS_WIDTH (already present).
- Add the FSM state enum mem_ctrl_state_t to CPU_package: IDLE, WRITE, READ_WAIT, CAPTURE, RESP, VREAD, VCHECK.
- One sub-module is natural: sat_counter (parameterised width, increment enable, async active-low clear), instantiated twice.

Test Plan:
- Store 0xC5 to 0x9, then load 0x9 -> Write_Enable high exactly 1 cycle; rsp_rdata=0xC5 exactly 2 cycles after load accept; store_count=1, load_count=1.
- Store 0x09 to 0xF and 0x0F to 0x1, then load 0xF and 0x1 -> responses 0x09 then 0x0F in order; Read_Enable and Write_Enable never high together.
- Load 0x9 with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata=0xC5 stable throughout; req_ready=0 until 1 cycle after rsp_ready=1.
- Assert reset_n=0 during READ_WAIT of a load at 0x1 -> outputs 0 immediately, req_ready=1 after release, no response, counters 0.
- Back-to-back req_valid with 0x10000 stores (CNT_WIDTH=16) -> store_count saturates at 0xFFFF.
- With MEM_STORE_VERIFY_EN and the memory model forced to corrupt address 0x3, store 0xAA to 0x3 -> verify_err=1 and stays set; a subsequent good store to 0x4 does not clear it.
